// File: rtl/hyper_todram_sched.sv
// rtl/hyper_todram_sched.sv - round-robin burst scheduler between LSAB section descriptors and the DRAM block mover
module hyper_todram_sched #(
   parameter logic [5:0] BURST_MAX = 6'd32
) (
   input  logic        CLK,
   input  logic        RST,
   input  logic        ENABLE,
   input  logic [3:0]  REQ,
   input  logic        CFG_WE,
   input  logic [1:0]  CFG_SECTION,
   input  logic [11:0] CFG_ADDR,
   input  logic [11:0] CFG_LEN,
   output logic        CFG_REJECT,
   output logic [11:0] MV_START_ADDRESS,
   output logic [5:0]  MV_COUNT_REQ,
   output logic [1:0]  MV_SECTION,
   output logic        MV_ISSUE,
   input  logic        MV_WORKING,
   input  logic [5:0]  MV_COUNT_SENT,
   output logic        BUSY,
   output logic [3:0]  DONE
);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ARM    = 2'd1,
      S_RUN    = 2'd2,
      S_UPDATE = 2'd3
   } state_t;

   state_t      state;
   state_t      state_nxt;

   // Per-section descriptors: next DRAM column and words still to move.
   logic [11:0] addr [4];
   logic [11:0] rem  [4];

   logic [1:0]  rr;
   logic [1:0]  sel;

   logic [3:0]  eligible;
   logic        grant_vld;
   logic [1:0]  grant_sec;
   logic [11:0] grant_rem;
   logic [5:0]  grant_cnt;

   logic        grant_fire;
   logic        do_update;
   logic [11:0] rem_after;

   logic        cfg_hit_busy;
   logic        cfg_load;

   // A section is a candidate only while it asks for service and has work left.
   always_comb begin
      eligible = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         eligible[i] = REQ[i] && (rem[i] != 12'd0);
      end
   end

   // First eligible section in rr, rr+1, rr+2, rr+3 order; the 2-bit add wraps naturally.
   always_comb begin
      grant_vld = 1'b0;
      grant_sec = rr;
      for (int i = 0; i < 4; i++) begin
         if (!grant_vld && eligible[rr + 2'(i)]) begin
            grant_vld = 1'b1;
            grant_sec = rr + 2'(i);
         end
      end
   end

   // Burst size is the remaining count clipped to BURST_MAX.
   always_comb begin
      grant_rem = rem[grant_sec];
      if (grant_rem > {6'd0, BURST_MAX}) begin
         grant_cnt = BURST_MAX;
      end else begin
         grant_cnt = grant_rem[5:0];
      end
   end

   // The active descriptor is frozen from grant until its UPDATE; writes to it are bounced.
   always_comb begin
      cfg_hit_busy = CFG_WE && (state != S_IDLE) && (CFG_SECTION == sel);
      cfg_load     = CFG_WE && !cfg_hit_busy;
      rem_after    = rem[sel] - {6'd0, MV_COUNT_SENT};
   end

   // State register; asynchronous reset drops any burst in flight.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state <= S_IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   // Next state plus the grant and update strobes that drive the datapath.
   always_comb begin
      state_nxt  = state;
      grant_fire = 1'b0;
      do_update  = 1'b0;
      case (state)
         S_IDLE: begin
            if (ENABLE && grant_vld) begin
               grant_fire = 1'b1;
               state_nxt  = S_ARM;
            end
         end
         S_ARM: begin
            if (MV_WORKING) begin
               state_nxt = S_RUN;
            end
         end
         S_RUN: begin
            if (!MV_WORKING) begin
               state_nxt = S_UPDATE;
            end
         end
         S_UPDATE: begin
            do_update = 1'b1;
            state_nxt = S_IDLE;
         end
         default: begin
            state_nxt = S_IDLE;
         end
      endcase
   end

   // Descriptor storage: config loads, or advance by what the mover actually sent.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         for (int i = 0; i < 4; i++) begin
            addr[i] <= 12'd0;
            rem[i]  <= 12'd0;
         end
      end else begin
         for (int i = 0; i < 4; i++) begin
            if (cfg_load && (CFG_SECTION == 2'(i))) begin
               addr[i] <= CFG_ADDR;
               rem[i]  <= CFG_LEN;
            end else if (do_update && (sel == 2'(i))) begin
               addr[i] <= addr[i] + {6'd0, MV_COUNT_SENT};
               rem[i]  <= rem_after;
            end
         end
      end
   end

   // Mover command registers: captured at grant and held until the next grant.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         MV_ISSUE         <= 1'b0;
         sel              <= 2'd0;
         MV_START_ADDRESS <= 12'd0;
         MV_COUNT_REQ     <= 6'd0;
      end else begin
         MV_ISSUE <= grant_fire;
         if (grant_fire) begin
            sel              <= grant_sec;
            MV_START_ADDRESS <= addr[grant_sec];
            MV_COUNT_REQ     <= grant_cnt;
         end
      end
   end

   // Pointer advance and single-cycle status pulses; rr moves even on an empty send.
   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         rr         <= 2'd0;
         DONE       <= 4'b0000;
         CFG_REJECT <= 1'b0;
      end else begin
         DONE       <= 4'b0000;
         CFG_REJECT <= cfg_hit_busy;
         if (do_update) begin
            rr <= sel + 2'd1;
            if (rem_after == 12'd0) begin
               DONE[sel] <= 1'b1;
            end
         end
      end
   end

   assign MV_SECTION = sel;
   assign BUSY       = (state != S_IDLE);

endmodule

// File: tb/tb_hyper_todram_sched.sv
// tb/tb_hyper_todram_sched.sv - table and scoreboard bench for hyper_todram_sched
module tb_hyper_todram_sched;

   logic        CLK = 1'b0;
   logic        RST;
   logic        ENABLE;
   logic [3:0]  REQ;
   logic        CFG_WE;
   logic [1:0]  CFG_SECTION;
   logic [11:0] CFG_ADDR;
   logic [11:0] CFG_LEN;
   logic        CFG_REJECT;
   logic [11:0] MV_START_ADDRESS;
   logic [5:0]  MV_COUNT_REQ;
   logic [1:0]  MV_SECTION;
   logic        MV_ISSUE;
   logic        MV_WORKING;
   logic [5:0]  MV_COUNT_SENT;
   logic        BUSY;
   logic [3:0]  DONE;

   int checks = 0;
   int errors = 0;

   // One burst: expected grant fields, the count the mover returns, expected DONE.
   typedef struct {
      logic [1:0]  sec;
      logic [11:0] addr;
      logic [5:0]  cnt;
      logic [5:0]  sent;
      logic [3:0]  done;
   } burst_t;

   burst_t tbl [0:23];
   burst_t sb [$];

   hyper_todram_sched #(.BURST_MAX(6'd32)) dut (
      .CLK(CLK),
      .RST(RST),
      .ENABLE(ENABLE),
      .REQ(REQ),
      .CFG_WE(CFG_WE),
      .CFG_SECTION(CFG_SECTION),
      .CFG_ADDR(CFG_ADDR),
      .CFG_LEN(CFG_LEN),
      .CFG_REJECT(CFG_REJECT),
      .MV_START_ADDRESS(MV_START_ADDRESS),
      .MV_COUNT_REQ(MV_COUNT_REQ),
      .MV_SECTION(MV_SECTION),
      .MV_ISSUE(MV_ISSUE),
      .MV_WORKING(MV_WORKING),
      .MV_COUNT_SENT(MV_COUNT_SENT),
      .BUSY(BUSY),
      .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic do_reset();
      RST           = 1'b0;
      ENABLE        = 1'b1;
      REQ           = 4'b0000;
      CFG_WE        = 1'b0;
      CFG_SECTION   = 2'd0;
      CFG_ADDR      = 12'd0;
      CFG_LEN       = 12'd0;
      MV_WORKING    = 1'b0;
      MV_COUNT_SENT = 6'd0;
      repeat (2) tick();
      RST = 1'b1;
      tick();
   endtask

   task automatic cfg_write(input logic [1:0] sec, input logic [11:0] a, input logic [11:0] len);
      CFG_WE      = 1'b1;
      CFG_SECTION = sec;
      CFG_ADDR    = a;
      CFG_LEN     = len;
      tick();
      CFG_WE      = 1'b0;
   endtask

   task automatic issue_check(input burst_t e, output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 64; i++) begin
         if (MV_ISSUE) begin
            ok = 1'b1;
            break;
         end
         tick();
      end
      if (!ok) begin
         checks++;
         errors++;
         $display("FAIL issue_timeout: got no ISSUE expected section %0d", e.sec);
      end else begin
         chk("issue_section", MV_SECTION, e.sec);
         chk("issue_addr", MV_START_ADDRESS, e.addr);
         chk("issue_count", MV_COUNT_REQ, e.cnt);
         chk("issue_busy", BUSY, 1);
      end
   endtask

   task automatic mover_work();
      int n;
      n = MV_COUNT_REQ;
      if (n < 1) n = 1;
      tick();
      tick();
      MV_WORKING = 1'b1;
      repeat (n) tick();
   endtask

   task automatic mover_finish(input logic [5:0] sent, input logic [3:0] exp_done);
      MV_WORKING    = 1'b0;
      MV_COUNT_SENT = sent;
      tick();
      chk("update_busy", BUSY, 1);
      tick();
      chk("done", DONE, exp_done);
      chk("idle_busy", BUSY, 0);
      tick();
      chk("done_pulse_len", DONE, 0);
   endtask

   task automatic push_range(input int lo, input int hi);
      for (int i = lo; i <= hi; i++) sb.push_back(tbl[i]);
   endtask

   task automatic run_expected();
      burst_t e;
      bit ok;
      while (sb.size() > 0) begin
         e = sb.pop_front();
         issue_check(e, ok);
         if (!ok) begin
            sb.delete();
            break;
         end
         mover_work();
         mover_finish(e.sent, e.done);
      end
   endtask

   task automatic no_issue_for(input int n, input string name);
      bit seen;
      seen = 1'b0;
      repeat (n) begin
         tick();
         if (MV_ISSUE) seen = 1'b1;
      end
      chk(name, seen, 0);
   endtask

   initial begin
      #200000;
      errors++;
      $display("FAIL watchdog: got timeout expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin
      burst_t e;
      bit ok;

      tbl[0]  = '{2'd1, 12'h010, 6'd10, 6'd10, 4'b0010};
      tbl[1]  = '{2'd0, 12'h000, 6'd32, 6'd32, 4'b0000};
      tbl[2]  = '{2'd0, 12'h020, 6'd32, 6'd32, 4'b0000};
      tbl[3]  = '{2'd0, 12'h040, 6'd32, 6'd32, 4'b0000};
      tbl[4]  = '{2'd0, 12'h060, 6'd4,  6'd4,  4'b0001};
      tbl[5]  = '{2'd0, 12'h000, 6'd32, 6'd32, 4'b0000};
      tbl[6]  = '{2'd1, 12'h100, 6'd32, 6'd32, 4'b0000};
      tbl[7]  = '{2'd2, 12'h200, 6'd32, 6'd32, 4'b0000};
      tbl[8]  = '{2'd3, 12'h300, 6'd32, 6'd32, 4'b0000};
      tbl[9]  = '{2'd0, 12'h020, 6'd8,  6'd8,  4'b0001};
      tbl[10] = '{2'd1, 12'h120, 6'd8,  6'd8,  4'b0010};
      tbl[11] = '{2'd2, 12'h220, 6'd8,  6'd8,  4'b0100};
      tbl[12] = '{2'd3, 12'h320, 6'd8,  6'd8,  4'b1000};
      tbl[13] = '{2'd2, 12'h200, 6'd20, 6'd0,  4'b0000};
      tbl[14] = '{2'd3, 12'h300, 6'd3,  6'd3,  4'b1000};
      tbl[15] = '{2'd2, 12'h200, 6'd20, 6'd5,  4'b0000};
      tbl[16] = '{2'd2, 12'h205, 6'd15, 6'd15, 4'b0100};
      tbl[17] = '{2'd0, 12'h040, 6'd8,  6'd4,  4'b0000};
      tbl[18] = '{2'd0, 12'h044, 6'd4,  6'd4,  4'b0001};
      tbl[19] = '{2'd0, 12'hFF0, 6'd32, 6'd32, 4'b0000};
      tbl[20] = '{2'd0, 12'h010, 6'd18, 6'd18, 4'b0001};
      tbl[21] = '{2'd1, 12'h100, 6'd32, 6'd32, 4'b0000};
      tbl[22] = '{2'd1, 12'h120, 6'd8,  6'd8,  4'b0010};
      tbl[23] = '{2'd1, 12'h123, 6'd20, 6'd20, 4'b0000};

      // reset values
      do_reset();
      chk("rst_issue", MV_ISSUE, 0);
      chk("rst_section", MV_SECTION, 0);
      chk("rst_addr", MV_START_ADDRESS, 0);
      chk("rst_count", MV_COUNT_REQ, 0);
      chk("rst_busy", BUSY, 0);
      chk("rst_done", DONE, 0);
      chk("rst_reject", CFG_REJECT, 0);

      // single section, whole descriptor in one burst
      cfg_write(2'd1, 12'h010, 12'd10);
      REQ = 4'b0010;
      push_range(0, 0);
      run_expected();
      no_issue_for(20, "single_no_more");
      REQ = 4'b0000;

      // burst splitting at BURST_MAX
      cfg_write(2'd0, 12'h000, 12'd100);
      REQ = 4'b0001;
      push_range(1, 4);
      run_expected();
      no_issue_for(10, "split_no_more");
      REQ = 4'b0000;

      // round-robin over all four sections
      do_reset();
      cfg_write(2'd0, 12'h000, 12'd40);
      cfg_write(2'd1, 12'h100, 12'd40);
      cfg_write(2'd2, 12'h200, 12'd40);
      cfg_write(2'd3, 12'h300, 12'd40);
      REQ = 4'b1111;
      push_range(5, 12);
      run_expected();
      REQ = 4'b0000;

      // empty send, then short send
      do_reset();
      cfg_write(2'd2, 12'h200, 12'd20);
      cfg_write(2'd3, 12'h300, 12'd3);
      REQ = 4'b1100;
      push_range(13, 16);
      run_expected();
      REQ = 4'b0000;

      // config collision with the active section, then the same write in IDLE
      do_reset();
      cfg_write(2'd0, 12'h040, 12'd8);
      REQ = 4'b0001;
      e = tbl[17];
      issue_check(e, ok);
      if (ok) begin
         mover_work();
         cfg_write(2'd0, 12'hFF0, 12'd50);
         chk("reject_pulse", CFG_REJECT, 1);
         tick();
         chk("reject_single", CFG_REJECT, 0);
         mover_finish(e.sent, e.done);
      end
      push_range(18, 18);
      run_expected();
      cfg_write(2'd0, 12'hFF0, 12'd50);
      chk("reject_idle", CFG_REJECT, 0);
      push_range(19, 20);
      run_expected();
      REQ = 4'b0000;

      // asynchronous reset in the middle of a burst
      do_reset();
      cfg_write(2'd1, 12'h123, 12'd20);
      REQ = 4'b0010;
      e = tbl[23];
      issue_check(e, ok);
      if (ok) mover_work();
      RST = 1'b0;
      #1;
      chk("arst_busy", BUSY, 0);
      chk("arst_issue", MV_ISSUE, 0);
      chk("arst_section", MV_SECTION, 0);
      chk("arst_addr", MV_START_ADDRESS, 0);
      chk("arst_count", MV_COUNT_REQ, 0);
      chk("arst_done", DONE, 0);
      MV_WORKING = 1'b0;
      tick();
      RST = 1'b1;
      no_issue_for(10, "arst_descr_cleared");
      REQ = 4'b0000;

      // ENABLE low mid-burst: burst finishes, no new grant until re-enabled
      do_reset();
      cfg_write(2'd1, 12'h100, 12'd40);
      REQ = 4'b0010;
      e = tbl[21];
      issue_check(e, ok);
      if (ok) begin
         mover_work();
         ENABLE = 1'b0;
         mover_finish(e.sent, e.done);
      end
      no_issue_for(20, "disabled_hold");
      chk("disabled_busy", BUSY, 0);
      ENABLE = 1'b1;
      push_range(22, 22);
      run_expected();
      REQ = 4'b0000;

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/hyper_todram_sched.md
# hyper_todram_sched

Scheduler for the LSAB-to-DRAM block mover. Holds a per-section transfer descriptor (DRAM column address and words remaining) for the four LSAB sections. It arbitrates round-robin among sections that request service and issues one bounded burst at a time to the mover. It sits between the hyperfabric control logic and the mover's ISSUE/WORKING/COUNT_SENT interface, and advances each descriptor by the count the mover actually sent.

## Interface
- BURST_MAX, 6'd32, maximum words per issued burst (legal 1..63)
- CLK  in  1  system clock; all state on rising edge
- RST  in  1  asynchronous, active-low reset
- ENABLE  in  1  1 = new grants allowed; 0 = finish current burst, then idle
- REQ  in  4  per-section service request, bit n = LSAB section n
- CFG_WE  in  1  write descriptor for CFG_SECTION
- CFG_SECTION  in  2  descriptor index
- CFG_ADDR  in  12  start DRAM column address
- CFG_LEN  in  12  words to move (0 = descriptor idle)
- CFG_REJECT  out  1  one-cycle pulse: previous write was dropped
- MV_START_ADDRESS  out  12  to mover START_ADDRESS
- MV_COUNT_REQ  out  6  to mover COUNT_REQ
- MV_SECTION  out  2  to mover SECTION
- MV_ISSUE  out  1  to mover ISSUE, one-cycle pulse
- MV_WORKING  in  1  from mover WORKING
- MV_COUNT_SENT  in  6  from mover COUNT_SENT
- BUSY  out  1  state != IDLE
- DONE  out  4  one-cycle pulse when section n's remaining count reaches 0

## Operation
- Per section n: addr[n] (12 b), rem[n] (12 b). Section n is eligible when REQ[n]=1 and rem[n]!=0.
- The round-robin pointer rr (2 b) sets search order rr, rr+1, rr+2, rr+3 (mod 4). It resets to 0.
- State machine:
  - IDLE: if ENABLE=1 and any section is eligible, choose the first eligible section in rr order as sel. Register MV_SECTION=sel, MV_START_ADDRESS=addr[sel], MV_COUNT_REQ=(rem[sel]>BURST_MAX)?BURST_MAX:rem[sel][5:0], and MV_ISSUE=1. Go to ARM.
  - ARM: MV_ISSUE=0. Wait for MV_WORKING=1, then go to RUN.
  - RUN: wait for MV_WORKING=0, then go to UPDATE.
  - UPDATE:
    - addr[sel] += MV_COUNT_SENT (mod 4096)
    - rem[sel] -= MV_COUNT_SENT
    - if the result is 0, pulse DONE[sel]
    - rr = sel+1
    - go to IDLE.
- MV_SECTION, MV_START_ADDRESS and MV_COUNT_REQ hold their values from ISSUE until the next grant.
- MV_COUNT_SENT is sampled only in UPDATE. A value of 0 (LSAB empty) is legal:
  - the descriptor is unchanged;
  - rr still advances, so the empty section cannot monopolise the mover.
- MV_COUNT_SENT > rem[sel] cannot occur, because COUNT_REQ ≤ rem. It is not checked.
- Config writes:
  - CFG_WE to a section other than sel, or any write while in IDLE, loads addr and rem on that edge.
  - CFG_WE to sel while in ARM, RUN or UPDATE is dropped, and CFG_REJECT pulses on the next cycle.
  - A write that lands in IDLE on the same cycle as a grant to that section takes effect. The grant uses the pre-write values.
- ENABLE=0 never aborts a burst in flight.
- The scheduler does not realign addresses. Even/odd pairing is the mover's job.

## Timing
- Reset values:
  - MV_ISSUE=0, MV_SECTION=0, MV_START_ADDRESS=0, MV_COUNT_REQ=0
  - BUSY=0, DONE=0, CFG_REJECT=0
  - all addr and rem = 0, rr=0, state=IDLE
- Asynchronous reset mid-burst returns the block to IDLE immediately. The mover is expected to be reset with it.
- Latency:
  - eligible REQ sampled in IDLE at edge k → MV_ISSUE high in cycle k+1;
  - mover WORKING rises about 2 cycles after ISSUE;
  - UPDATE runs 1 cycle after WORKING falls;
  - the next grant decision is taken in the IDLE cycle after UPDATE.
- Minimum spacing between ISSUE pulses is 5 cycles plus the burst length.
- DONE and CFG_REJECT are registered single-cycle pulses.
- BUSY is high from the ISSUE cycle through UPDATE inclusive.

## Test plan
- Single section: cfg sec1 addr=0x010 len=10, REQ=0010, mover sends all → one ISSUE with COUNT_REQ=10, SECTION=1, START=0x010; UPDATE leaves addr=0x01A, rem=0; DONE=0010 pulse.
- Burst splitting: sec0 len=100, BURST_MAX=32, full sends → COUNT_REQ sequence 32, 32, 32, 4; START 0x000, 0x020, 0x040, 0x060; one DONE at the end.
- Round-robin: all four sections len=40, REQ=1111 → grant order 0, 1, 2, 3, 0, 1, 2, 3; second-round COUNT_REQ=8 each.
- Short or empty send: sec2 len=20, mover returns COUNT_SENT=0, then 5 → first UPDATE leaves the descriptor unchanged and gives the next grant to sec3 if eligible; after the second, addr advances by 5 and rem=15; no DONE.
- Config collision: CFG_WE to sel during RUN → descriptor unchanged, CFG_REJECT pulses once; the same write in IDLE is accepted.
- Reset and enable: assert RST low during RUN → all outputs return to reset values at once. ENABLE=0 during RUN → the burst completes and UPDATE happens, but no new ISSUE until ENABLE=1.
